lcd_seq: RTL and testbench

Command sequencer that sits in front of lcd_drv and drives its 9-bit ready/valid command port ({rs, data}).
- After reset it waits for LCD power-up, then issues the HD44780 initialisation sequence.
- It then accepts ASCII characters and clear requests from the user side.
- It inserts DDRAM address commands automatically, so text wraps across the COLS x ROWS display.

---
 rtl/lcd_seq.sv | 191 +++++++++++++++++++
 tb/tb_lcd_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_seq.sv
// lcd_seq: HD44780 command sequencer in front of lcd_drv.
// After a power-up wait it plays the init ROM. It then turns user
// characters and clear requests into {rs, data} commands, and inserts
// DDRAM address commands so that text wraps across a COLS x ROWS panel.
module lcd_seq #(
  parameter int unsigned COLS      = 16,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned INIT_WAIT = 1500000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] char_i,
  input  logic       char_valid_i,
  output logic       char_ready_o,
  input  logic       clr_i,
  output logic       clr_done_o,
  output logic       init_done_o,
  output logic [8:0] cmd_o,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned CNT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_WAIT - 1);
  localparam logic             ROW_LAST = 1'(ROWS - 1);

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_DDRAM    = 8'h80;
  localparam logic [7:0] ROW1_OFFSET  = 8'h40;

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_INIT     = 3'd1,
    S_IDLE     = 3'd2,
    S_CHAR     = 3'd3,
    S_ADDR     = 3'd4,
    S_CLR      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             row_q, row_d;
  logic [8:0]       cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             clr_done_q, clr_done_d;
  logic             init_done_q, init_done_d;

  logic             xfer_c;
  logic             row_wrap_c;

  // Init ROM: function set, display on, clear, entry mode increment.
  function automatic logic [7:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    init_rom = (ROWS == 1) ? 8'h30 : 8'h38;
      2'd1:    init_rom = 8'h0C;
      2'd2:    init_rom = 8'h01;
      default: init_rom = 8'h06;
    endcase
  endfunction

  // Handshake completion and the row that follows the current one.
  assign xfer_c     = cmd_valid_q && cmd_ready_i;
  assign row_wrap_c = (row_q == ROW_LAST) ? 1'b0 : (row_q + 1'b1);

  // Only IDLE accepts characters, and a pending clear blocks them.
  assign char_ready_o = (state_q == S_IDLE) && !clr_i;

  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cmd_valid_q;
  assign clr_done_o  = clr_done_q;
  assign init_done_o = init_done_q;

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      col_q       <= '0;
      row_q       <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      clr_done_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      clr_done_q  <= clr_done_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic; each command is loaded on the transition into its state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    col_d       = col_q;
    row_d       = row_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    clr_done_d  = 1'b0;
    init_done_d = init_done_q;

    case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = S_INIT;
          cmd_d       = {1'b0, init_rom(2'd0)};
          cmd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_INIT: begin
        if (xfer_c) begin
          if (idx_q == 2'd3) begin
            state_d     = S_IDLE;
            cmd_valid_d = 1'b0;
            init_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
            cmd_d = {1'b0, init_rom(idx_q + 2'd1)};
          end
        end
      end

      S_IDLE: begin
        if (clr_i) begin
          state_d     = S_CLR;
          cmd_d       = {1'b0, CMD_CLEAR};
          cmd_valid_d = 1'b1;
        end else if (char_valid_i) begin
          state_d     = S_CHAR;
          cmd_d       = {1'b1, char_i};
          cmd_valid_d = 1'b1;
        end
      end

      S_CHAR: begin
        if (xfer_c) begin
          if (col_q != COL_LAST) begin
            col_d       = col_q + COL_W'(1);
            state_d     = S_IDLE;
            cmd_valid_d = 1'b0;
          end else begin
            col_d       = '0;
            row_d       = row_wrap_c;
            state_d     = S_ADDR;
            cmd_d       = {1'b0, CMD_DDRAM | (row_wrap_c ? ROW1_OFFSET : 8'h00)};
            cmd_valid_d = 1'b1;
          end
        end
      end

      S_ADDR: begin
        if (xfer_c) begin
          state_d     = S_IDLE;
          cmd_valid_d = 1'b0;
        end
      end

      S_CLR: begin
        if (xfer_c) begin
          col_d       = '0;
          row_d       = 1'b0;
          clr_done_d  = 1'b1;
          state_d     = S_IDLE;
          cmd_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = S_PWR_WAIT;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_seq.sv
// Directed bench for lcd_seq with a scoreboard of expected command words.
module tb_lcd_seq;

  localparam int unsigned COLS      = 16;
  localparam int unsigned ROWS      = 2;
  localparam int unsigned INIT_WAIT = 20;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] char_i;
  logic       char_valid_i;
  logic       char_ready_o;
  logic       clr_i;
  logic       clr_done_o;
  logic       init_done_o;
  logic [8:0] cmd_o;
  logic       cmd_valid_o;
  logic       cmd_ready_i;

  int checks     = 0;
  int errors     = 0;
  int xfers      = 0;
  int clr_pulses = 0;

  logic [8:0] exp_q[$];
  logic [9:0] exp_word;

  lcd_seq #(
    .COLS(COLS),
    .ROWS(ROWS),
    .INIT_WAIT(INIT_WAIT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .char_i(char_i),
    .char_valid_i(char_valid_i),
    .char_ready_o(char_ready_o),
    .clr_i(clr_i),
    .clr_done_o(clr_done_o),
    .init_done_o(init_done_o),
    .cmd_o(cmd_o),
    .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i)
  );

  always #5 clk = ~clk;

  // Scoreboard: each transfer pops and compares the oldest expected word.
  always @(negedge clk) begin
    if (!rst_i && cmd_valid_o && cmd_ready_i) begin
      xfers++;
      checks++;
      exp_word = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 10'h3FF;
      assert ({1'b0, cmd_o} === exp_word) else begin
        errors++;
        $error("FAIL cmd_xfer: observed 0x%03h expected 0x%03h (3ff = none)", cmd_o, exp_word);
      end
    end
    if (clr_done_o) clr_pulses++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    int n;
    exp_q.push_back({1'b1, c});
    char_i       = c;
    char_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!char_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("char_accept_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    char_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) step();
    step();
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_clr_done();
    int n;
    for (n = 0; n < 300; n++) begin
      step();
      if (clr_done_o) break;
    end
    chk("clr_done_seen", 32'(clr_done_o), 1);
  endtask

  task automatic do_clear();
    int p0;
    exp_q.push_back(9'h001);
    p0    = clr_pulses;
    clr_i = 1'b1;
    wait_clr_done();
    clr_i = 1'b0;
    step();
    step();
    chk("clr_pulse_once", 32'(clr_pulses - p0), 1);
  endtask

  task automatic do_init();
    int n;
    exp_q.delete();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
    rst_i        = 1'b1;
    cmd_ready_i  = 1'b1;
    clr_i        = 1'b0;
    char_valid_i = 1'b0;
    char_i       = 8'h00;
    step();
    step();
    chk("rst_cmd", 32'(cmd_o), 0);
    chk("rst_cmd_valid", 32'(cmd_valid_o), 0);
    chk("rst_char_ready", 32'(char_ready_o), 0);
    chk("rst_clr_done", 32'(clr_done_o), 0);
    chk("rst_init_done", 32'(init_done_o), 0);
    rst_i = 1'b0;
    for (n = 1; n <= 100; n++) begin
      step();
      if (cmd_valid_o) break;
    end
    chk("pwr_wait_cycles", 32'(n), INIT_WAIT);
    for (n = n + 1; n <= 200; n++) begin
      step();
      if (init_done_o) break;
    end
    chk("init_done_cycle", 32'(n), INIT_WAIT + 4);
    chk("init_drained", 32'(exp_q.size()), 0);
    chk("idle_char_ready", 32'(char_ready_o), 1);
  endtask

  initial begin
    int x0;
    int p0;
    logic bad;

    // Power-up wait and init ROM with the driver always ready.
    do_init();

    // Backpressure: 'A' held for 50 cycles, then exactly one transfer.
    cmd_ready_i = 1'b0;
    send_char(8'h41);
    x0  = xfers;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (cmd_o !== 9'h141 || cmd_valid_o !== 1'b1 || char_ready_o !== 1'b0) bad = 1'b1;
    end
    chk("bp_stable", 32'(bad), 0);
    chk("bp_no_xfer", 32'(xfers - x0), 0);
    cmd_ready_i = 1'b1;
    step();
    chk("bp_one_xfer", 32'(xfers - x0), 1);
    chk("bp_valid_drop", 32'(cmd_valid_o), 0);
    chk("bp_back_idle", 32'(char_ready_o), 1);
    step();
    step();
    chk("bp_still_one", 32'(xfers - x0), 1);

    // Line wrap from column 0: 16 characters, then row-1 address.
    do_clear();
    for (int i = 0; i < 16; i++) send_char(8'(8'h30 + i));
    exp_q.push_back(9'h0C0);
    send_char(8'h41);
    drain("line_wrap_drain");

    // Row wrap: address 0x0C0 after the 16th, 0x080 after the 32nd.
    do_clear();
    for (int i = 0; i < 32; i++) begin
      send_char(8'(8'h40 + i));
      if (i == 15) exp_q.push_back(9'h0C0);
      if (i == 31) exp_q.push_back(9'h080);
    end
    drain("row_wrap_drain");

    // Back at column 0: five characters with no address, leaving col=5.
    for (int i = 0; i < 5; i++) send_char(8'(8'h61 + i));
    drain("col5_drain");

    // Clear and character together: the clear wins.
    exp_q.push_back(9'h001);
    p0           = clr_pulses;
    clr_i        = 1'b1;
    char_i       = 8'h7A;
    char_valid_i = 1'b1;
    @(negedge clk);
    chk("clr_prio_char_ready", 32'(char_ready_o), 0);
    wait_clr_done();
    clr_i        = 1'b0;
    char_valid_i = 1'b0;
    step();
    step();
    chk("clr_prio_pulse_once", 32'(clr_pulses - p0), 1);

    // After the clear col=0: no address until 16 characters have landed.
    for (int i = 0; i < 16; i++) send_char(8'(8'h5A - i));
    exp_q.push_back(9'h0C0);
    drain("post_clr_drain");

    // Reset while a character command is stalled.
    cmd_ready_i = 1'b0;
    send_char(8'h52);
    step();
    chk("pre_rst_valid", 32'(cmd_valid_o), 1);
    rst_i = 1'b1;
    step();
    chk("mid_rst_valid", 32'(cmd_valid_o), 0);
    chk("mid_rst_init_done", 32'(init_done_o), 0);
    do_init();
    send_char(8'h21);
    drain("after_reinit_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
